// File: rtl/stopwatch_counter_if.sv
// Control pulses into the stopwatch counting stage and display data out to
// the seven-segment decoders. The counter is the slave side.
interface stopwatch_counter_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [23:0] bcd;
    logic [5:0]  dp_n;
    logic        running;
    logic        wrap;

    modport master (
        output start_stop,
        output clear,
        output lap,
        input  bcd,
        input  dp_n,
        input  running,
        input  wrap
    );

    modport slave (
        input  start_stop,
        input  clear,
        input  lap,
        output bcd,
        output dp_n,
        output running,
        output wrap
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and BCD counter (MM:SS.hh) with start/stop, clear and
// lap-freeze control. Every output is a register loaded from the next-state
// decode, so control pulses are visible on the same edge that samples them
// and no input reaches an output combinationally.
module stopwatch_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    stopwatch_counter_if.slave sw
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_ZERO = '0;
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
    localparam logic [23:0]   COUNT_ZERO = 24'h000000;
    localparam logic [23:0]   COUNT_MAX  = 24'h595999;
    localparam logic [5:0]    DP_NORMAL  = 6'b101011;
    localparam logic [5:0]    DP_LAP     = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // One-hundredth increment with carries rippling through all six digits.
    // Tens of seconds and tens of minutes roll at 5, the rest at 9; a digit
    // already at or past its limit is treated as the limit so it can never
    // escape its range.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if ((i == 3) || (i == 5)) begin
                lim = 4'd5;
            end else begin
                lim = 4'd9;
            end
            if (carry) begin
                if (r[i*4 +: 4] >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    state_t          state_r;
    logic [PW-1:0]   presc_r;
    logic [23:0]     count_r;
    logic [23:0]     lap_r;
    logic [23:0]     bcd_r;
    logic [5:0]      dp_n_r;
    logic            running_r;
    logic            wrap_r;

    state_t          state_nxt_s;
    logic [PW-1:0]   presc_nxt_s;
    logic [23:0]     count_nxt_s;
    logic [23:0]     lap_nxt_s;
    logic [23:0]     bcd_nxt_s;
    logic [5:0]      dp_n_nxt_s;
    logic            running_nxt_s;
    logic            wrap_nxt_s;

    // Next-state decode: prescaler/count advance first, then the control
    // pulses act on top of it (clear > start_stop > lap, illegal ones dropped).
    always_comb begin
        state_nxt_s   = state_r;
        presc_nxt_s   = presc_r;
        count_nxt_s   = count_r;
        lap_nxt_s     = lap_r;
        wrap_nxt_s    = 1'b0;
        bcd_nxt_s     = count_r;
        dp_n_nxt_s    = DP_NORMAL;
        running_nxt_s = 1'b0;

        if ((state_r == ST_RUN) || (state_r == ST_LAP)) begin
            if (presc_r == PRESC_MAX) begin
                presc_nxt_s = PRESC_ZERO;
                count_nxt_s = bcd_inc(count_r);
                wrap_nxt_s  = (count_r == COUNT_MAX);
            end else begin
                presc_nxt_s = presc_r + PRESC_ONE;
            end
        end else begin
            presc_nxt_s = presc_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (sw.start_stop) begin
                    state_nxt_s = ST_RUN;
                    presc_nxt_s = PRESC_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sw.start_stop) begin
                    state_nxt_s = ST_STOP;
                end else if (sw.lap) begin
                    // Freeze includes an increment made on this same edge.
                    state_nxt_s = ST_LAP;
                    lap_nxt_s   = count_nxt_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (sw.start_stop) begin
                    state_nxt_s = ST_STOP;
                end else if (sw.lap) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_STOP: begin
                if (sw.clear) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = COUNT_ZERO;
                    presc_nxt_s = PRESC_ZERO;
                end else if (sw.start_stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = COUNT_ZERO;
                presc_nxt_s = PRESC_ZERO;
            end
        endcase

        case (state_nxt_s)
            ST_LAP: begin
                bcd_nxt_s     = lap_nxt_s;
                dp_n_nxt_s    = DP_LAP;
                running_nxt_s = 1'b1;
            end
            ST_RUN: begin
                bcd_nxt_s     = count_nxt_s;
                dp_n_nxt_s    = DP_NORMAL;
                running_nxt_s = 1'b1;
            end
            default: begin
                bcd_nxt_s     = count_nxt_s;
                dp_n_nxt_s    = DP_NORMAL;
                running_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counting registers and registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            count_r   <= COUNT_ZERO;
            lap_r     <= COUNT_ZERO;
            bcd_r     <= COUNT_ZERO;
            dp_n_r    <= DP_NORMAL;
            running_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            count_r   <= count_nxt_s;
            lap_r     <= lap_nxt_s;
            bcd_r     <= bcd_nxt_s;
            dp_n_r    <= dp_n_nxt_s;
            running_r <= running_nxt_s;
            wrap_r    <= wrap_nxt_s;
        end
    end

    assign sw.bcd     = bcd_r;
    assign sw.dp_n    = dp_n_r;
    assign sw.running = running_r;
    assign sw.wrap    = wrap_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with DIV = 10. Stimulus pushes the
// hand-computed expected outputs for the current cycle into a queue; a
// monitor pops and compares them on the falling edge of that cycle.
module tb_stopwatch_counter;

    localparam logic [5:0] DP_NORM = 6'b101011;
    localparam logic [5:0] DP_LAP  = 6'b101010;

    typedef struct {
        int          cyc;
        string       name;
        logic [23:0] bcd;
        logic [5:0]  dp;
        logic        run;
        logic        wr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    stopwatch_counter_if sw_if();

    stopwatch_counter #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw     (sw_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic lp);
        sw_if.start_stop = ss;
        sw_if.clear      = cl;
        sw_if.lap        = lp;
        step(1);
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [23:0] b,
                              input logic [5:0] d, input logic r, input logic w);
        exp_t e;
        e.cyc  = cyc_cnt;
        e.name = nm;
        e.bcd  = b;
        e.dp   = d;
        e.run  = r;
        e.wr   = w;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every expectation due in this cycle.
    initial begin
        forever begin
            @(negedge clk);
            while ((sb_q.size() > 0) && (sb_q[0].cyc <= cyc_cnt)) begin
                mon_e = sb_q.pop_front();
                n_checks++;
                if ((sw_if.bcd !== mon_e.bcd) || (sw_if.dp_n !== mon_e.dp) ||
                    (sw_if.running !== mon_e.run) || (sw_if.wrap !== mon_e.wr)) begin
                    n_fail++;
                    $display("FAIL %s: got bcd=%h dp_n=%b running=%b wrap=%b, expected bcd=%h dp_n=%b running=%b wrap=%b",
                             mon_e.name, sw_if.bcd, sw_if.dp_n, sw_if.running, sw_if.wrap,
                             mon_e.bcd, mon_e.dp, mon_e.run, mon_e.wr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        step(3);
        expect_out("reset_state", 24'h000000, DP_NORM, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(2);
        expect_out("idle_after_reset", 24'h000000, DP_NORM, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        expect_out("idle_ignores_clear_lap", 24'h000000, DP_NORM, 1'b0, 1'b0);

        // Start and count.
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("start", 24'h000000, DP_NORM, 1'b1, 1'b0);
        step(9);
        expect_out("before_first_tick", 24'h000000, DP_NORM, 1'b1, 1'b0);
        step(1);
        expect_out("first_tick", 24'h000001, DP_NORM, 1'b1, 1'b0);
        step(90);
        expect_out("tenth_tick", 24'h000010, DP_NORM, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("clear_in_run_ignored", 24'h000010, DP_NORM, 1'b1, 1'b0);

        // Pause 4 edges after a tick, hold, resume.
        step(2);
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("stop", 24'h000010, DP_NORM, 1'b0, 1'b0);
        step(25);
        expect_out("stop_hold_a", 24'h000010, DP_NORM, 1'b0, 1'b0);
        step(25);
        expect_out("stop_hold_b", 24'h000010, DP_NORM, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("resume", 24'h000010, DP_NORM, 1'b1, 1'b0);
        step(5);
        expect_out("resume_before_tick", 24'h000010, DP_NORM, 1'b1, 1'b0);
        step(1);
        expect_out("resume_tick_at_6", 24'h000011, DP_NORM, 1'b1, 1'b0);

        // Lap captured on a tick edge, then released on a tick edge.
        step(1119);
        expect_out("before_lap", 24'h000122, DP_NORM, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("lap_capture", 24'h000123, DP_LAP, 1'b1, 1'b0);
        step(199);
        expect_out("lap_frozen", 24'h000123, DP_LAP, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("lap_release", 24'h000143, DP_NORM, 1'b1, 1'b0);

        // Priority cases.
        pulse(1'b1, 1'b0, 1'b1);
        expect_out("start_stop_over_lap", 24'h000143, DP_NORM, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        expect_out("clear_over_start_stop", 24'h000000, DP_NORM, 1'b0, 1'b0);

        // Wrap: preload 59:59.99 just before a tick.
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("restart", 24'h000000, DP_NORM, 1'b1, 1'b0);
        step(8);
        force dut.count_r = 24'h595999;
        step(1);
        release dut.count_r;
        expect_out("preload", 24'h595999, DP_NORM, 1'b1, 1'b0);
        step(1);
        expect_out("wrap_pulse", 24'h000000, DP_NORM, 1'b1, 1'b1);
        step(1);
        expect_out("wrap_one_cycle", 24'h000000, DP_NORM, 1'b1, 1'b0);
        step(9);
        expect_out("count_after_wrap", 24'h000001, DP_NORM, 1'b1, 1'b0);

        // LAP side paths.
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("lap_again", 24'h000001, DP_LAP, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("clear_in_lap_ignored", 24'h000001, DP_LAP, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("lap_to_stop", 24'h000001, DP_NORM, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("lap_in_stop_ignored", 24'h000001, DP_NORM, 1'b0, 1'b0);

        // Run to 00:03.07 (prescaler held at 3) then reset asynchronously.
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("resume_to_307", 24'h000001, DP_NORM, 1'b1, 1'b0);
        step(3057);
        expect_out("count_307", 24'h000307, DP_NORM, 1'b1, 1'b0);
        step(1);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sw_if.bcd !== 24'h000000) begin
            n_fail++;
            $display("FAIL async_reset_bcd: got bcd=%h", sw_if.bcd);
        end
        n_checks++;
        if (sw_if.dp_n !== DP_NORM) begin
            n_fail++;
            $display("FAIL async_reset_dp: got dp_n=%b", sw_if.dp_n);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_running: got running=%b", sw_if.running);
        end
        n_checks++;
        if (sw_if.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_wrap: got wrap=%b", sw_if.wrap);
        end
        expect_out("async_reset", 24'h000000, DP_NORM, 1'b0, 1'b0);
        step(2);
        reset_n = 1'b1;
        step(20);
        expect_out("idle_after_async_reset", 24'h000000, DP_NORM, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5; i++) begin
            if (sb_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, expected bcd=%h", mon_e.name, mon_e.bcd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-base and BCD counting stage of the stopwatch, sitting directly upstream of the BCD-to-seven-segment decoders. It divides the system clock into a 1/100 s tick, counts elapsed time as six BCD digits (MM:SS.hh), and handles start/stop, clear and lap-freeze control. It also drives a per-digit active-low decimal-point mask. Each decoder instance takes one 4-bit digit and one dp bit from this block.

## Interface

Parameters:
- CLK_HZ, 50000000: system clock frequency. Must be an integer multiple of TICK_HZ.
- TICK_HZ, 100: count rate. DIV = CLK_HZ/TICK_HZ must be ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  **one clock; reset is asynchronous and active-low**
- start_stop  in  1  one-cycle pulse (already debounced and edge-detected upstream)
- clear  in  1  one-cycle pulse
- lap  in  1  one-cycle pulse
- bcd  out  24  displayed digits, 4 bits each:
  - [3:0] hundredths units, [7:4] hundredths tens
  - [11:8] seconds units, [15:12] seconds tens
  - [19:16] minutes units, [23:20] minutes tens
- dp_n  out  6  decimal points, one per digit in bcd order; 0 = lit
- running  out  1  high in RUN and LAP
- wrap  out  1  one-cycle pulse on rollover 59:59.99 → 00:00.00

## Operation

- Reset (asynchronous, reset_n low):
  - state = IDLE, prescaler = 0, count = 0, lap register = 0.
  - Outputs: bcd = 0, dp_n = 6'b101011, running = 0, wrap = 0.
- States and transitions:
  - IDLE: start_stop → RUN. clear and lap are ignored.
  - RUN: start_stop → STOP. lap → LAP, capturing the live count, including any increment on that same edge, into the lap register. clear is ignored.
  - LAP: lap → RUN. start_stop → STOP. clear is ignored. Counting continues in LAP.
  - STOP: start_stop → RUN. clear → IDLE, zeroing count and prescaler. lap is ignored.
- Simultaneous pulses: priority is clear > start_stop > lap. Only the highest-priority pulse that is legal in the current state acts; the others are dropped.
- Prescaler:
  - Advances only in RUN and LAP.
  - At DIV−1 it returns to 0 and increments the count on the same edge.
  - It holds its value in STOP, so the fractional tick is kept across pause/resume.
  - It is forced to 0 on the IDLE → RUN edge.
- Digit rollover: hundredths units and tens 0–9, seconds units 0–9, seconds tens 0–5, minutes units 0–9, minutes tens 0–5. Carries ripple within the same edge.
- Overflow: an increment at 59:59.99 gives 00:00.00 and asserts wrap for exactly that one cycle. Counting continues.
- Display:
  - bcd shows the lap register in LAP and the live count in all other states.
  - Digits never take values outside their ranges (no 0xA–0xF).
- Decimal points:
  - dp_n[2] = 0 always (seconds.hundredths separator).
  - dp_n[4] = 0 always (minutes.seconds separator).
  - dp_n[0] = 0 only in LAP (lap indicator).
  - All other dp_n bits = 1.

## Timing

- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Control latency: a pulse sampled at edge N changes state, running, bcd source and dp_n as of edge N.
- First increment: the count reads 00:00.01 exactly DIV edges after the edge that sampled start_stop in IDLE.
- Resume from STOP: the next increment occurs after DIV − (prescaler value held at stop) edges.
- Lap release: when lap is sampled in LAP, bcd shows the live count from that edge onward, including any increment made on that edge.
- Reset mid-count: asynchronous assertion clears everything immediately. After deassertion the block stays in IDLE until start_stop.

## Test plan

All scenarios use CLK_HZ=10, TICK_HZ=1, so DIV=10.
- Reset: hold reset_n low mid-RUN at count 00:03.07 → bcd=0, running=0, wrap=0 and dp_n=6'b101011 immediately, with no clk edge needed.
- Start and count: start_stop in IDLE, then 10 edges → bcd=24'h000001 and running=1. After 100 edges from start → bcd=24'h000010.
- Pause and resume: stop 4 edges after a tick, wait 50 edges, then restart → the next increment arrives 6 edges after the restart edge, and bcd is unchanged during STOP.
- Lap: lap at bcd=24'h000123 → bcd frozen at 000123 and dp_n[0]=0 while the live count advances. Second lap after 20 ticks → bcd=24'h000143 and dp_n[0]=1.
- Wrap: preload to 59:59.99 (run or force), then one tick → bcd=24'h000000, wrap high for exactly 1 cycle, running stays 1.
- Priority and illegal pulses:
  - clear in RUN → ignored, count unchanged.
  - clear and start_stop on the same edge in STOP → IDLE with bcd=0.
  - start_stop and lap on the same edge in RUN → STOP with dp_n[0]=1.
